pico_run_ctrl: RTL

Run controller for the pico core. Sequences execution by holding the core in reset and gating it with a clock enable. Supports start, stop, single-step, one PC breakpoint and a cycle-budget timeout, and reports why execution ended. Sits between the testbench/debug host and `core`, consuming the core's `addr_pc` and `halt_o` and driving its reset and enable.

---
 rtl/pico_pkg.sv | 25 ++
 rtl/pico_run_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pico_pkg.sv
// Shared widths and enumerations for the pico core and its run controller.
package pico;

  localparam int unsigned A     = 8;
  localparam int unsigned W_CNT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    PAUSED = 3'd4,
    DONE   = 3'd5
  } runState;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    HALT    = 3'd1,
    TIMEOUT = 3'd2,
    STOP    = 3'd3,
    BP      = 3'd4,
    STEPPED = 3'd5
  } stopCause;

endpackage

// File: rtl/pico_run_ctrl.sv
// Run controller for the pico core: holds the core in reset, gates its clock
// enable, and sequences start/stop/step/breakpoint/timeout.
module pico_run_ctrl #(
  parameter int unsigned A     = pico::A,
  parameter int unsigned W_CNT = pico::W_CNT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             step_i,
  input  logic             bp_en_i,
  input  logic [A-1:0]     bp_addr_i,
  input  logic [W_CNT-1:0] max_cycles_i,
  input  logic [A-1:0]     pc_addr_i,
  input  logic             halt_i,
  output logic             core_n_rst_o,
  output logic             core_en_o,
  output logic [2:0]       state_o,
  output logic [2:0]       cause_o,
  output logic [W_CNT-1:0] cycles_o,
  output logic             done_o
);
  import pico::*;

  runState          state_q, state_d;
  stopCause         cause_q, cause_d;
  logic             skip_bp_q, skip_bp_d;
  logic [W_CNT-1:0] cycles_q, cycles_d;
  logic             done_q, done_d;
  logic             core_en;
  logic             clr_cnt;
  logic [W_CNT:0]   cycles_inc;
  logic             budget_hit;
  logic             bp_hit;

  // One extra bit keeps a saturated counter from aliasing onto a small budget.
  assign cycles_inc = {1'b0, cycles_q} + {{W_CNT{1'b0}}, 1'b1};
  assign budget_hit = (max_cycles_i != {W_CNT{1'b0}}) && (cycles_inc == {1'b0, max_cycles_i});
  assign bp_hit     = bp_en_i && (pc_addr_i == bp_addr_i) && !skip_bp_q;

  // Next-state, cause, skip and clock-enable gating.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    skip_bp_d = skip_bp_q;
    core_en   = 1'b0;
    clr_cnt   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = CLR;
          cause_d   = NONE;
          skip_bp_d = 1'b0;
          clr_cnt   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      CLR: state_d = RUN;
      RUN: begin
        if (halt_i) begin
          state_d = DONE;
          cause_d = HALT;
        end else if (budget_hit) begin
          core_en   = 1'b1;
          skip_bp_d = 1'b0;
          state_d   = DONE;
          cause_d   = TIMEOUT;
        end else if (stop_i) begin
          state_d = PAUSED;
          cause_d = STOP;
        end else if (bp_hit) begin
          state_d = PAUSED;
          cause_d = BP;
        end else begin
          core_en   = 1'b1;
          skip_bp_d = 1'b0;
        end
      end
      STEP: begin
        if (halt_i) begin
          state_d = DONE;
          cause_d = HALT;
        end else begin
          core_en = 1'b1;
          state_d = PAUSED;
          cause_d = STEPPED;
        end
      end
      PAUSED: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (step_i) begin
          state_d   = STEP;
          skip_bp_d = 1'b1;
        end else if (start_i) begin
          state_d   = RUN;
          skip_bp_d = 1'b1;
        end else begin
          state_d = PAUSED;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_cnt) begin
      cycles_d = {W_CNT{1'b0}};
    end else if (core_en && !(&cycles_q)) begin
      cycles_d = cycles_inc[W_CNT-1:0];
    end else begin
      cycles_d = cycles_q;
    end

    done_d = (state_d == DONE) && (state_q != DONE);
  end

  // State, cause, skip flag, cycle counter and done pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cause_q   <= NONE;
      skip_bp_q <= 1'b0;
      cycles_q  <= {W_CNT{1'b0}};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      skip_bp_q <= skip_bp_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
    end
  end

  assign core_n_rst_o = !((state_q == IDLE) || (state_q == CLR));
  assign core_en_o    = core_en;
  assign state_o      = state_q;
  assign cause_o      = cause_q;
  assign cycles_o     = cycles_q;
  assign done_o       = done_q;

endmodule
